// File: rtl/ftdi_sync_fifo_device_if.sv
`default_nettype none
// ============================================================================
// Module   : ftdi_sync_fifo_device_if
// Brief    : FTDI synchronous-FIFO bridge bus plus the two AXI-Stream byte
//            channels of the emulated device.
// Revision : 1.0 - initial release
// ============================================================================
interface ftdi_sync_fifo_device_if;
    logic       ftdi_rd_n;
    logic       ftdi_oe_n;
    logic       ftdi_wr_n;
    logic       ftdi_rxf_n;
    logic       ftdi_txe_n;
    logic [7:0] ftdi_data_i;
    logic [7:0] ftdi_data_o;
    logic       ftdi_data_oe;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;

    // Bridge and host side: drives strobes, bus data and stream inputs
    modport master (
        output ftdi_rd_n, ftdi_oe_n, ftdi_wr_n, ftdi_data_i,
               s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  ftdi_rxf_n, ftdi_txe_n, ftdi_data_o, ftdi_data_oe,
               s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    // Emulated FTDI device side
    modport slave (
        input  ftdi_rd_n, ftdi_oe_n, ftdi_wr_n, ftdi_data_i,
               s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output ftdi_rxf_n, ftdi_txe_n, ftdi_data_o, ftdi_data_oe,
               s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface
`default_nettype wire

// File: rtl/ftdi_sync_fifo_device.sv
`default_nettype none
// ============================================================================
// Module   : ftdi_sync_fifo_device
// Brief    : Emulated FTDI FT2232H-style synchronous FIFO device with RX
//            (host->bridge) and TX (bridge->host) byte FIFOs and sticky errors.
// Revision : 1.0 - initial release
// ============================================================================
module ftdi_sync_fifo_device #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  wire logic                        clk,
    input  wire logic                        res,
    ftdi_sync_fifo_device_if.slave           bus,
    output logic [$clog2(RX_DEPTH):0]        rx_level,
    output logic [$clog2(TX_DEPTH):0]        tx_level,
    output logic [3:0]                       err,
    input  wire logic                        err_clr
);

    localparam int c_RX_AW = $clog2(RX_DEPTH);
    localparam int c_TX_AW = $clog2(TX_DEPTH);
    localparam logic [c_RX_AW:0] c_RX_FULL = (c_RX_AW+1)'(RX_DEPTH);
    localparam logic [c_TX_AW:0] c_TX_FULL = (c_TX_AW+1)'(TX_DEPTH);

    logic [7:0]         r_rx_mem [RX_DEPTH];
    logic [7:0]         r_tx_mem [TX_DEPTH];
    logic [c_RX_AW-1:0] r_rx_wr_ptr;
    logic [c_RX_AW-1:0] r_rx_rd_ptr;
    logic [c_TX_AW-1:0] r_tx_wr_ptr;
    logic [c_TX_AW-1:0] r_tx_rd_ptr;
    logic [c_RX_AW:0]   r_rx_level;
    logic [c_TX_AW:0]   r_tx_level;
    logic [c_RX_AW:0]   w_rx_level_next;
    logic [c_TX_AW:0]   w_tx_level_next;
    logic               r_rxf_n;
    logic               r_txe_n;
    logic [3:0]         r_err;
    logic [3:0]         w_err_new;
    logic               w_s_tready;
    logic               w_m_tvalid;
    logic               w_rx_push;
    logic               w_rx_pop;
    logic               w_tx_push;
    logic               w_tx_pop;

    assign w_s_tready = (r_rx_level != c_RX_FULL);
    assign w_m_tvalid = (r_tx_level != '0);

    // Bridge-side handshakes qualify on the registered flags, so a byte pushed
    // this cycle is never visible to the bridge until the flag updates.
    assign w_rx_push = bus.s_axis_tvalid & w_s_tready;
    assign w_rx_pop  = ~r_rxf_n & ~bus.ftdi_rd_n & ~bus.ftdi_oe_n;
    assign w_tx_push = ~r_txe_n & ~bus.ftdi_wr_n & bus.ftdi_oe_n;
    assign w_tx_pop  = w_m_tvalid & bus.m_axis_tready;

    assign w_err_new[0] = ~bus.ftdi_rd_n & bus.ftdi_oe_n;
    assign w_err_new[1] = ~bus.ftdi_rd_n & ~bus.ftdi_oe_n & r_rxf_n;
    assign w_err_new[2] = ~bus.ftdi_wr_n & r_txe_n;
    assign w_err_new[3] = ~bus.ftdi_wr_n & ~bus.ftdi_oe_n;

    always_comb begin
        w_rx_level_next = r_rx_level;
        case ({w_rx_push, w_rx_pop})
            2'b10:   w_rx_level_next = r_rx_level + 1'b1;
            2'b01:   w_rx_level_next = r_rx_level - 1'b1;
            default: w_rx_level_next = r_rx_level;
        endcase
    end

    always_comb begin
        w_tx_level_next = r_tx_level;
        case ({w_tx_push, w_tx_pop})
            2'b10:   w_tx_level_next = r_tx_level + 1'b1;
            2'b01:   w_tx_level_next = r_tx_level - 1'b1;
            default: w_tx_level_next = r_tx_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_level  <= '0;
            r_rxf_n     <= 1'b1;
        end else begin
            if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
            if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
            r_rx_level <= w_rx_level_next;
            r_rxf_n    <= (w_rx_level_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_level  <= '0;
            r_txe_n     <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
            if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
            r_tx_level <= w_tx_level_next;
            r_txe_n    <= (w_tx_level_next == c_TX_FULL);
        end
    end

    // Storage is deliberately unreset; stale bytes sit behind the pointers.
    always_ff @(posedge clk) begin
        if (w_rx_push && !res) r_rx_mem[r_rx_wr_ptr] <= bus.s_axis_tdata;
        if (w_tx_push && !res) r_tx_mem[r_tx_wr_ptr] <= bus.ftdi_data_i;
    end

    // A clear never hides an error raised in the same cycle.
    always_ff @(posedge clk) begin
        if (res) begin
            r_err <= '0;
        end else if (err_clr) begin
            r_err <= w_err_new;
        end else begin
            r_err <= r_err | w_err_new;
        end
    end

    assign bus.ftdi_rxf_n    = r_rxf_n;
    assign bus.ftdi_txe_n    = r_txe_n;
    assign bus.ftdi_data_o   = r_rx_mem[r_rx_rd_ptr];
    assign bus.ftdi_data_oe  = ~bus.ftdi_oe_n;
    assign bus.s_axis_tready = w_s_tready;
    assign bus.m_axis_tdata  = r_tx_mem[r_tx_rd_ptr];
    assign bus.m_axis_tvalid = w_m_tvalid;
    assign rx_level          = r_rx_level;
    assign tx_level          = r_tx_level;
    assign err               = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ftdi_sync_fifo_device.sv
`default_nettype none
// ============================================================================
// Module   : tb_ftdi_sync_fifo_device
// Brief    : Directed self-checking bench for ftdi_sync_fifo_device.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ftdi_sync_fifo_device;

    logic       clk;
    logic       res;
    logic       err_clr;
    logic [4:0] rx_level;
    logic [4:0] tx_level;
    logic [3:0] err;
    int         checks;
    int         failures;

    ftdi_sync_fifo_device_if bus ();

    ftdi_sync_fifo_device #(.RX_DEPTH(16), .TX_DEPTH(16)) dut (
        .clk      (clk),
        .res      (res),
        .bus      (bus.slave),
        .rx_level (rx_level),
        .tx_level (tx_level),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ftdi_rd_n     = 1'b1;
        bus.ftdi_oe_n     = 1'b1;
        bus.ftdi_wr_n     = 1'b1;
        bus.ftdi_data_i   = 8'h00;
        bus.s_axis_tdata  = 8'h00;
        bus.s_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b0;
        err_clr           = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        res = 1'b1;
        tick();
        tick();
        res = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rx_level !== 5'd0) begin failures++; $display("FAIL reset_rx_level got=%0d exp=0", rx_level); end
        checks++; if (tx_level !== 5'd0) begin failures++; $display("FAIL reset_tx_level got=%0d exp=0", tx_level); end
        checks++; if (bus.ftdi_rxf_n !== 1'b1) begin failures++; $display("FAIL reset_rxf_n got=%b exp=1", bus.ftdi_rxf_n); end
        checks++; if (bus.ftdi_txe_n !== 1'b0) begin failures++; $display("FAIL reset_txe_n got=%b exp=0", bus.ftdi_txe_n); end
        checks++; if (bus.m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%b exp=0", bus.m_axis_tvalid); end
        checks++; if (bus.s_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_s_tready got=%b exp=1", bus.s_axis_tready); end
        checks++; if (err !== 4'h0) begin failures++; $display("FAIL reset_err got=%h exp=0", err); end
    endtask

    task automatic test_rx_read();
        logic [7:0] exp_bytes [3];
        exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
        do_reset();
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = exp_bytes[0];
        tick();
        checks++; if (bus.ftdi_rxf_n !== 1'b0) begin failures++; $display("FAIL rx_rxf_n_after_push got=%b exp=0", bus.ftdi_rxf_n); end
        bus.s_axis_tdata = exp_bytes[1];
        tick();
        bus.s_axis_tdata = exp_bytes[2];
        tick();
        bus.s_axis_tvalid = 1'b0;
        checks++; if (rx_level !== 5'd3) begin failures++; $display("FAIL rx_level_3 got=%0d exp=3", rx_level); end
        bus.ftdi_oe_n = 1'b0;
        #1;
        checks++; if (bus.ftdi_data_oe !== 1'b1) begin failures++; $display("FAIL rx_data_oe got=%b exp=1", bus.ftdi_data_oe); end
        tick();
        bus.ftdi_rd_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.ftdi_data_o !== exp_bytes[i]) begin failures++; $display("FAIL rx_data_o[%0d] got=%h exp=%h", i, bus.ftdi_data_o, exp_bytes[i]); end
            tick();
        end
        bus.ftdi_rd_n = 1'b1;
        bus.ftdi_oe_n = 1'b1;
        #1;
        checks++; if (bus.ftdi_data_oe !== 1'b0) begin failures++; $display("FAIL rx_data_oe_off got=%b exp=0", bus.ftdi_data_oe); end
        checks++; if (bus.ftdi_rxf_n !== 1'b1) begin failures++; $display("FAIL rx_rxf_n_empty got=%b exp=1", bus.ftdi_rxf_n); end
        checks++; if (rx_level !== 5'd0) begin failures++; $display("FAIL rx_level_empty got=%0d exp=0", rx_level); end
        checks++; if (err !== 4'h0) begin failures++; $display("FAIL rx_err got=%h exp=0", err); end
    endtask

    task automatic test_rx_full();
        do_reset();
        bus.s_axis_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.s_axis_tdata = 8'(8'h40 + i);
            tick();
        end
        checks++; if (rx_level !== 5'd16) begin failures++; $display("FAIL rxfull_level got=%0d exp=16", rx_level); end
        checks++; if (bus.s_axis_tready !== 1'b0) begin failures++; $display("FAIL rxfull_tready got=%b exp=0", bus.s_axis_tready); end
        bus.s_axis_tvalid = 1'b0;
        bus.ftdi_oe_n = 1'b0;
        tick();
        bus.ftdi_rd_n = 1'b0;
        #1;
        checks++; if (bus.ftdi_data_o !== 8'h40) begin failures++; $display("FAIL rxfull_head got=%h exp=40", bus.ftdi_data_o); end
        tick();
        bus.ftdi_rd_n = 1'b1;
        bus.ftdi_oe_n = 1'b1;
        checks++; if (bus.s_axis_tready !== 1'b1) begin failures++; $display("FAIL rxfull_tready_after_read got=%b exp=1", bus.s_axis_tready); end
        checks++; if (rx_level !== 5'd15) begin failures++; $display("FAIL rxfull_level_after_read got=%0d exp=15", rx_level); end
        checks++; if (bus.ftdi_data_o !== 8'h41) begin failures++; $display("FAIL rxfull_next_head got=%h exp=41", bus.ftdi_data_o); end
    endtask

    task automatic test_tx_full();
        do_reset();
        bus.ftdi_wr_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.ftdi_data_i = 8'(8'hA0 + i);
            if (i == 15) begin
                checks++; if (bus.ftdi_txe_n !== 1'b0) begin failures++; $display("FAIL tx_txe_n_at_15 got=%b exp=0", bus.ftdi_txe_n); end
            end
            tick();
        end
        checks++; if (bus.ftdi_txe_n !== 1'b1) begin failures++; $display("FAIL tx_txe_n_full got=%b exp=1", bus.ftdi_txe_n); end
        checks++; if (tx_level !== 5'd16) begin failures++; $display("FAIL tx_level_full got=%0d exp=16", tx_level); end
        checks++; if (err !== 4'h0) begin failures++; $display("FAIL tx_err_before_overrun got=%h exp=0", err); end
        bus.ftdi_data_i = 8'hEE;
        tick();
        bus.ftdi_wr_n = 1'b1;
        checks++; if (err !== 4'b0100) begin failures++; $display("FAIL tx_overrun_err got=%h exp=4", err); end
        checks++; if (tx_level !== 5'd16) begin failures++; $display("FAIL tx_level_after_overrun got=%0d exp=16", tx_level); end
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 8'(8'hA0 + i)) begin
                failures++;
                $display("FAIL tx_drain[%0d] got valid=%b data=%h exp valid=1 data=%h", i, bus.m_axis_tvalid, bus.m_axis_tdata, 8'(8'hA0 + i));
            end
            tick();
        end
        bus.m_axis_tready = 1'b0;
        checks++; if (bus.m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL tx_drained_tvalid got=%b exp=0", bus.m_axis_tvalid); end
        checks++; if (bus.ftdi_txe_n !== 1'b0) begin failures++; $display("FAIL tx_drained_txe_n got=%b exp=0", bus.ftdi_txe_n); end
    endtask

    task automatic test_errors();
        do_reset();
        bus.ftdi_oe_n = 1'b0;
        bus.ftdi_rd_n = 1'b0;
        tick();
        bus.ftdi_rd_n = 1'b1;
        bus.ftdi_oe_n = 1'b1;
        checks++; if (err !== 4'b0010) begin failures++; $display("FAIL err_underrun got=%h exp=2", err); end
        checks++; if (rx_level !== 5'd0) begin failures++; $display("FAIL err_underrun_level got=%0d exp=0", rx_level); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 4'h0) begin failures++; $display("FAIL err_clear1 got=%h exp=0", err); end
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 8'h5A;
        tick();
        bus.s_axis_tvalid = 1'b0;
        bus.ftdi_rd_n = 1'b0;
        tick();
        bus.ftdi_rd_n = 1'b1;
        checks++; if (err !== 4'b0001) begin failures++; $display("FAIL err_rd_no_oe got=%h exp=1", err); end
        checks++; if (rx_level !== 5'd1) begin failures++; $display("FAIL err_rd_no_oe_level got=%0d exp=1", rx_level); end
        bus.ftdi_wr_n = 1'b0;
        bus.ftdi_oe_n = 1'b0;
        tick();
        bus.ftdi_wr_n = 1'b1;
        bus.ftdi_oe_n = 1'b1;
        checks++; if (err !== 4'b1001) begin failures++; $display("FAIL err_contention got=%h exp=9", err); end
        checks++; if (tx_level !== 5'd0) begin failures++; $display("FAIL err_contention_tx_level got=%0d exp=0", tx_level); end
        err_clr = 1'b1;
        bus.ftdi_rd_n = 1'b0;
        tick();
        bus.ftdi_rd_n = 1'b1;
        checks++; if (err !== 4'b0001) begin failures++; $display("FAIL err_clr_precedence got=%h exp=1", err); end
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 4'h0) begin failures++; $display("FAIL err_clear2 got=%h exp=0", err); end
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        bus.s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.s_axis_tdata = 8'(i);
            tick();
        end
        bus.s_axis_tvalid = 1'b0;
        bus.ftdi_oe_n = 1'b0;
        tick();
        bad = 0;
        bus.s_axis_tvalid = 1'b1;
        bus.ftdi_rd_n = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.s_axis_tdata = 8'(i + 4);
            #1;
            checks++;
            if (bus.ftdi_data_o !== 8'(i) || rx_level !== 5'd4) begin
                failures++;
                if (bad < 5) $display("FAIL b2b[%0d] got data=%h level=%0d exp data=%h level=4", i, bus.ftdi_data_o, rx_level, 8'(i));
                bad++;
            end
            tick();
        end
        bus.s_axis_tvalid = 1'b0;
        bus.ftdi_rd_n = 1'b1;
        bus.ftdi_oe_n = 1'b1;
        checks++; if (rx_level !== 5'd4) begin failures++; $display("FAIL b2b_final_level got=%0d exp=4", rx_level); end
        checks++; if (bus.ftdi_data_o !== 8'd100) begin failures++; $display("FAIL b2b_final_head got=%h exp=64", bus.ftdi_data_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.s_axis_tvalid = 1'b1;
        bus.ftdi_wr_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.s_axis_tdata = 8'(8'h70 + i);
            bus.ftdi_data_i  = 8'(8'hC0 + i);
            if (i == 3) bus.ftdi_wr_n = 1'b1;
            tick();
        end
        checks++; if (rx_level !== 5'd5) begin failures++; $display("FAIL mid_rx_level got=%0d exp=5", rx_level); end
        checks++; if (tx_level !== 5'd3) begin failures++; $display("FAIL mid_tx_level got=%0d exp=3", tx_level); end
        bus.ftdi_wr_n = 1'b0;
        res = 1'b1;
        tick();
        res = 1'b0;
        idle_inputs();
        checks++; if (rx_level !== 5'd0 || tx_level !== 5'd0) begin failures++; $display("FAIL mid_levels got rx=%0d tx=%0d exp 0/0", rx_level, tx_level); end
        checks++; if (bus.ftdi_rxf_n !== 1'b1 || bus.ftdi_txe_n !== 1'b0) begin failures++; $display("FAIL mid_flags got rxf_n=%b txe_n=%b exp 1/0", bus.ftdi_rxf_n, bus.ftdi_txe_n); end
        checks++; if (bus.m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL mid_m_tvalid got=%b exp=0", bus.m_axis_tvalid); end
        tick();
        checks++; if (rx_level !== 5'd0 || tx_level !== 5'd0) begin failures++; $display("FAIL mid_levels_hold got rx=%0d tx=%0d exp 0/0", rx_level, tx_level); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        res      = 1'b1;
        idle_inputs();
        test_reset();
        test_rx_read();
        test_rx_full();
        test_tx_full();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ftdi_sync_fifo_device.md
FTDI_SYNC_FIFO_DEVICE -- requirements
Module: ftdi_sync_fifo_device

Interface
REQ-001 SHALL have parameter RX_DEPTH, default 16, depth of host-to-FPGA byte FIFO (power of 2, >=2).
REQ-002 SHALL have parameter TX_DEPTH, default 16, depth of FPGA-to-host byte FIFO (power of 2, >=2).
REQ-003 SHALL have port clk  in  1  single clock; the emulated ftdi_clko; all logic on rising edge.
REQ-004 SHALL have port res  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports ftdi_rd_n, ftdi_oe_n, ftdi_wr_n  in  1 each  bridge strobes, active-low.
REQ-006 SHALL have port ftdi_rxf_n  out  1  low = RX FIFO holds a readable byte.
REQ-007 SHALL have port ftdi_txe_n  out  1  low = TX FIFO can accept a byte.
REQ-008 SHALL have port ftdi_data_i  in  8  bus value driven by bridge.
REQ-009 SHALL have ports ftdi_data_o  out  8, ftdi_data_oe  out  1  device bus drive value and enable.
REQ-010 SHALL have ports s_axis_tdata  in  8, s_axis_tvalid  in  1, s_axis_tready  out  1  host bytes into RX FIFO.
REQ-011 SHALL have ports m_axis_tdata  out  8, m_axis_tvalid  out  1, m_axis_tready  in  1  bridge bytes out of TX FIFO.
REQ-012 SHALL have ports rx_level  out  $clog2(RX_DEPTH)+1, tx_level  out  $clog2(TX_DEPTH)+1  FIFO occupancy.
REQ-013 SHALL have ports err  out  4  sticky protocol errors, err_clr  in  1  clears err.

Function
REQ-014 RX FIFO push SHALL occur when s_axis_tvalid & s_axis_tready; s_axis_tready = (rx_level != RX_DEPTH), independent of same-cycle pop.
REQ-015 RX pop SHALL occur when ~ftdi_rxf_n & ~ftdi_rd_n & ~ftdi_oe_n; one byte per cycle.
REQ-016 ftdi_data_o SHALL combinationally equal the RX FIFO head byte (first-word fall-through).
REQ-017 ftdi_data_oe SHALL equal ~ftdi_oe_n combinationally.
REQ-018 TX push SHALL occur when ~ftdi_txe_n & ~ftdi_wr_n & ftdi_oe_n, capturing ftdi_data_i.
REQ-019 TX pop SHALL occur when m_axis_tvalid & m_axis_tready; m_axis_tvalid = (tx_level != 0); m_axis_tdata = TX head.
REQ-020 ftdi_rxf_n SHALL be registered: next value = (rx_level_next == 0).
REQ-021 ftdi_txe_n SHALL be registered: next value = (tx_level_next == TX_DEPTH).
REQ-022 Levels SHALL update +1 push only, -1 pop only, unchanged on simultaneous push and pop.
REQ-023 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty derived from level only.
REQ-024 Empty RX with same-cycle push SHALL NOT pop (rxf_n high); rxf_n falls the cycle after the push.
REQ-025 Full TX with same-cycle AXIS pop SHALL NOT accept a write (txe_n high); txe_n falls the next cycle.
REQ-026 err[0] SHALL set on ~ftdi_rd_n while ftdi_oe_n high (read without OE); no pop.
REQ-027 err[1] SHALL set on ~ftdi_rd_n & ~ftdi_oe_n while ftdi_rxf_n high (read underrun); no pop.
REQ-028 err[2] SHALL set on ~ftdi_wr_n while ftdi_txe_n high (write overrun); byte dropped.
REQ-029 err[3] SHALL set on ~ftdi_wr_n & ~ftdi_oe_n (bus contention); no TX push.
REQ-030 err bits SHALL be sticky; err_clr SHALL clear them, a same-cycle new error taking precedence.

Reset
REQ-031 On res, pointers, levels, err SHALL be 0; ftdi_rxf_n=1, ftdi_txe_n=0, m_axis_tvalid=0, s_axis_tready=1.
REQ-032 Reset mid-transfer SHALL discard all FIFO contents; no push/pop during a res cycle.
REQ-033 FIFO memory contents SHALL need no reset.

Verification
REQ-034 Push 0x11,0x22,0x33 via s_axis; rxf_n low 1 cycle after first push; oe_n low then rd_n low 3 cycles -> data_o 0x11,0x22,0x33, rxf_n high after third, err=0.
REQ-035 Hold s_axis_tvalid 20 cycles, no reads -> 16 bytes accepted, tready low at rx_level=16; one read then tready high next cycle.
REQ-036 Bridge writes 0xA0..0xAF with m_axis_tready=0 -> txe_n high at tx_level=16; 17th wr_n cycle sets err[2]; m_axis then yields 0xA0..0xAF in order.
REQ-037 rd_n low with oe_n high -> err[0]=1, rx_level unchanged; wr_n & oe_n low -> err[3]=1; err_clr -> err=0.
REQ-038 Continuous simultaneous s_axis push and bridge read at rx_level=4, 100 cycles -> rx_level stays 4, bytes in order across pointer wrap.
REQ-039 Assert res with rx_level=5, tx_level=3 -> next cycle both 0, rxf_n=1, txe_n=0, m_axis_tvalid=0.
